// File: rtl/wb_regfile_unit_pkg.sv
// Shared types and constants for the write-back / register-file slice.
package wb_regfile_unit_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    // Architectural zero register: reads as 0, writes are dropped.
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_regfile_unit_regfile_16x16.sv
// Register file: one write port, two combinational read ports, synchronous reset.
module regfile_16x16
    import wb_regfile_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Entry 0 is only ever cleared, so it holds zero forever.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == ADDR_W'(REG_ZERO)) ? '0 : mem_reg[raddr1];
    assign rdata2 = (raddr2 == ADDR_W'(REG_ZERO)) ? '0 : mem_reg[raddr2];

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage: accepts EX/MEM results, waits for load data with a timeout,
// and commits through a one-entry WB register. Define WB_BYPASS_EN to forward wb_data to reads.
module wb_regfile_unit
    import wb_regfile_unit_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_rdata,
    output logic [DATA_W-1:0] rs2_rdata,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              load_err
);

    localparam int                CNT_W       = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(LOAD_TIMEOUT - 1);

    wb_state_t         state_reg,    state_next;
    logic [CNT_W-1:0]  cnt_reg,      cnt_next;
    logic [ADDR_W-1:0] rd_lat_reg,   rd_lat_next;
    logic              wb_valid_reg, wb_valid_next;
    logic [ADDR_W-1:0] wb_rd_reg,    wb_rd_next;
    logic [DATA_W-1:0] wb_data_reg,  wb_data_next;
    logic              ex_ready_c;
    logic              load_err_c;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            rd_lat_reg   <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rd_lat_reg   <= rd_lat_next;
            wb_valid_reg <= wb_valid_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rd_lat_next   = rd_lat_reg;
        wb_valid_next = 1'b0;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
        ex_ready_c    = 1'b0;
        load_err_c    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ex_ready_c = 1'b1;
                if (ex_valid) begin
                    if (ex_is_load) begin
                        rd_lat_next = ex_rd;
                        cnt_next    = '0;
                        state_next  = ST_LOAD_WAIT;
                    end else if (ex_wen) begin
                        wb_valid_next = 1'b1;
                        wb_rd_next    = ex_rd;
                        wb_data_next  = ex_alu_res;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // Data arriving on the last allowed cycle beats the timeout.
                if (mem_rvalid) begin
                    wb_valid_next = 1'b1;
                    wb_rd_next    = rd_lat_reg;
                    wb_data_next  = mem_rdata;
                    state_next    = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    load_err_c = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ex_ready = ex_ready_c;
    assign stall    = ~ex_ready_c;
    assign load_err = load_err_c;
    assign wb_valid = wb_valid_reg;
    assign wb_rd    = wb_rd_reg;
    assign wb_data  = wb_data_reg;

    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

    regfile_16x16 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .srst   (rst_n),
        .we     (wb_valid_reg),
        .waddr  (wb_rd_reg),
        .wdata  (wb_data_reg),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    logic [ADDR_W-1:0] rd_addr_arr [2];
    logic [DATA_W-1:0] rf_data_arr [2];
    logic [DATA_W-1:0] rd_data_arr [2];

    assign rd_addr_arr[0] = rs1_addr;
    assign rd_addr_arr[1] = rs2_addr;
    assign rf_data_arr[0] = rf_rdata1;
    assign rf_data_arr[1] = rf_rdata2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef WB_BYPASS_EN
            assign rd_data_arr[gi] = (wb_valid_reg && (wb_rd_reg == rd_addr_arr[gi]) &&
                                      (rd_addr_arr[gi] != ADDR_W'(REG_ZERO)))
                                     ? wb_data_reg : rf_data_arr[gi];
`else
            // Pending write becomes visible only after it lands in the array.
            assign rd_data_arr[gi] = rf_data_arr[gi];
`endif
        end
    endgenerate

    assign rs1_rdata = rd_data_arr[0];
    assign rs2_rdata = rd_data_arr[1];

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit; honours WB_BYPASS_EN when defined.
module tb_wb_regfile_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_wen, ex_is_load;
    logic [3:0]  ex_rd;
    logic [15:0] ex_alu_res;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [15:0] rs1_rdata, rs2_rdata;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        stall, load_err;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t exp_e;

    always #5 clk = ~clk;

    wb_regfile_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_alu_res (ex_alu_res),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_rdata  (rs1_rdata),
        .rs2_rdata  (rs2_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall      (stall),
        .load_err   (load_err)
    );

    // Every WB pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got rd=%0d data=%h required no write", wb_rd, wb_data);
            end else begin
                exp_e = exp_q.pop_front();
                if (wb_rd !== exp_e.rd || wb_data !== exp_e.data) begin
                    errors++;
                    $display("FAIL wb_write got rd=%0d data=%h required rd=%0d data=%h",
                             wb_rd, wb_data, exp_e.rd, exp_e.data);
                end else begin
                    $display("wb write rd=%0d data=%h", wb_rd, wb_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid   = 1'b0;
        ex_wen     = 1'b0;
        ex_is_load = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        rs1_addr = a;
        rs2_addr = a;
        #1;
        d = rs1_rdata;
    endtask

    // Returns in the cycle where wb_valid is expected high.
    task automatic issue_alu(input logic [3:0] rd, input logic [15:0] d);
        ex_valid   = 1'b1;
        ex_wen     = 1'b1;
        ex_is_load = 1'b0;
        ex_rd      = rd;
        ex_alu_res = d;
        exp_q.push_back(wr_t'({rd, d}));
        step();
        idle_in();
    endtask

    // Returns in the first LOAD_WAIT cycle.
    task automatic issue_load(input logic [3:0] rd);
        ex_valid   = 1'b1;
        ex_wen     = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = rd;
        step();
        idle_in();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_n = 1'b1;
        idle_in();
        ex_rd = '0; ex_alu_res = '0; mem_rdata = '0; rs1_addr = '0; rs2_addr = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_rd, wb_data, load_err, ex_ready, stall} !== {1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got wbv=%b rd=%0d data=%h err=%b rdy=%b stall=%b required 0 0 0000 0 1 0",
                     wb_valid, wb_rd, wb_data, load_err, ex_ready, stall);
        end
        read_reg(4'd7, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read got %h required 0000", d);
        end
        $display("reset done");
    endtask

    task automatic test_alu_write();
        logic [15:0] d;
        issue_alu(4'd3, 16'h1234);
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb_valid got %b required 1", wb_valid);
        end
        read_reg(4'd3, d);
        checks++;
        if (d !== (BYP ? 16'h1234 : 16'h0000)) begin
            errors++;
            $display("FAIL alu_same_cycle_read got %h required %h", d, BYP ? 16'h1234 : 16'h0000);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_wb_pulse got %b required 0", wb_valid);
        end
        read_reg(4'd3, d);
        checks++;
        if (d !== 16'h1234) begin
            errors++;
            $display("FAIL alu_read_r3 got %h required 1234", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b0;
        ex_rd = 4'd1; ex_alu_res = 16'hA1A1;
        exp_q.push_back(wr_t'({4'd1, 16'hA1A1}));
        step();
        ex_rd = 4'd2; ex_alu_res = 16'hB2B2;
        exp_q.push_back(wr_t'({4'd2, 16'hB2B2}));
        checks++;
        if (ex_ready !== 1'b1 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got rdy=%b wbv=%b required 1 1", ex_ready, wb_valid);
        end
        step();
        idle_in();
        step();
        read_reg(4'd1, d);
        checks++;
        if (d !== 16'hA1A1) begin
            errors++;
            $display("FAIL b2b_r1 got %h required a1a1", d);
        end
        read_reg(4'd2, d);
        checks++;
        if (d !== 16'hB2B2) begin
            errors++;
            $display("FAIL b2b_r2 got %h required b2b2", d);
        end
    endtask

    task automatic test_load();
        logic [15:0] d;
        int stall_cycles = 0;
        issue_load(4'd5);
        for (int k = 1; k <= 5; k++) begin
            mem_rvalid = (k == 5);
            mem_rdata  = 16'hBEEF;
            if (k == 5) exp_q.push_back(wr_t'({4'd5, 16'hBEEF}));
            #1;
            if (stall === 1'b1 && ex_ready === 1'b0) stall_cycles++;
            step();
        end
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if (stall_cycles != 5 || stall !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_stall got stall_cycles=%0d stall=%b wbv=%b required 5 0 1",
                     stall_cycles, stall, wb_valid);
        end
        step();
        read_reg(4'd5, d);
        checks++;
        if (d !== 16'hBEEF) begin
            errors++;
            $display("FAIL load_r5 got %h required beef", d);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        issue_alu(4'd6, 16'h6666);
        step();
        issue_load(4'd6);
        for (int k = 1; k <= 15; k++) begin
            mem_rvalid = 1'b0;
            #1;
            checks++;
            if (load_err !== (k == 15)) begin
                errors++;
                $display("FAIL timeout_err_cycle%0d got %b required %b", k, load_err, (k == 15));
            end
            step();
        end
        checks++;
        if (ex_ready !== 1'b1 || load_err !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after got rdy=%b err=%b wbv=%b required 1 0 0", ex_ready, load_err, wb_valid);
        end
        read_reg(4'd6, d);
        checks++;
        if (d !== 16'h6666) begin
            errors++;
            $display("FAIL timeout_r6 got %h required 6666", d);
        end
        $display("timeout load rd=6 done");
    endtask

    task automatic test_coincident();
        logic [15:0] d;
        issue_load(4'd7);
        for (int k = 1; k <= 15; k++) begin
            mem_rvalid = (k == 15);
            mem_rdata  = 16'h00A5;
            if (k == 15) exp_q.push_back(wr_t'({4'd7, 16'h00A5}));
            #1;
            if (k == 15) begin
                checks++;
                if (load_err !== 1'b0) begin
                    errors++;
                    $display("FAIL coincident_err got %b required 0", load_err);
                end
            end
            step();
        end
        mem_rvalid = 1'b0;
        step();
        read_reg(4'd7, d);
        checks++;
        if (d !== 16'h00A5) begin
            errors++;
            $display("FAIL coincident_r7 got %h required 00a5", d);
        end
    endtask

    task automatic test_r0();
        logic [15:0] d;
        issue_alu(4'd0, 16'hFFFF);
        read_reg(4'd0, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL r0_same_cycle got %h required 0000", d);
        end
        step();
        read_reg(4'd0, d);
        checks++;
        if (d !== 16'h0000 || rs2_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL r0_after got %h/%h required 0000", d, rs2_rdata);
        end
    endtask

    task automatic test_idle_rvalid();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h7777;
        step();
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_rvalid got wbv=%b rdy=%b required 0 1", wb_valid, ex_ready);
        end
    endtask

    task automatic test_reset_wb();
        logic [15:0] d;
        issue_alu(4'd9, 16'h9999);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        read_reg(4'd9, d);
        checks++;
        if (d !== 16'h0000 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wb_r9 got %h wbv=%b required 0000 0", d, wb_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] d;
        int bad = 0;
        issue_alu(4'd4, 16'h4444);
        step();
        issue_load(4'd8);
        step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5555;
        #1;
        checks++;
        if (ex_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_idle got rdy=%b stall=%b required 1 0", ex_ready, stall);
        end
        step();
        mem_rvalid = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_nowrite got wbv=%b required 0", wb_valid);
        end
        step();
        for (int a = 0; a < 16; a++) begin
            read_reg(4'(a), d);
            if (d !== 16'h0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_load_reads got %0d nonzero registers required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_load();
        test_timeout();
        test_coincident();
        test_r0();
        test_idle_rvalid();
        test_reset_wb();
        test_reset_mid_load();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile_unit.md
WB_REGFILE_UNIT -- requirements
Module: wb_regfile_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high; ports named clk and rst_n.
REQ-002 Parameter DATA_W, 16, register/data width.
REQ-003 Parameter ADDR_W, 4, register address width (16 registers).
REQ-004 Parameter LOAD_TIMEOUT, 15, max cycles waiting for load response.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  synchronous active-high reset.
REQ-007 ex_valid  in  1  EX/MEM result offered.
REQ-008 ex_ready  out  1  result accepted this cycle when ex_valid&ex_ready.
REQ-009 ex_wen  in  1  instruction writes rd.
REQ-010 ex_is_load  in  1  result comes from memory.
REQ-011 ex_rd  in  ADDR_W  destination register.
REQ-012 ex_alu_res  in  DATA_W  ALU result.
REQ-013 mem_rvalid  in  1  load data valid.
REQ-014 mem_rdata  in  DATA_W  load data.
REQ-015 rs1_addr, rs2_addr  in  ADDR_W  decode read addresses.
REQ-016 rs1_rdata, rs2_rdata  out  DATA_W  combinational read data to decode.
REQ-017 wb_valid  out  1  WB register holds a pending write.
REQ-018 wb_rd  out  ADDR_W; wb_data  out  DATA_W  pending write.
REQ-019 stall  out  1  pipeline hold; load_err  out  1  timeout pulse.

Function
REQ-020 FSM states SHALL be IDLE and LOAD_WAIT; ex_ready=1 only in IDLE; stall=~ex_ready.
REQ-021 IDLE, accepted, ex_wen=1, ex_is_load=0: WB register SHALL load {ex_rd, ex_alu_res}; wb_valid=1 next cycle (latency 1).
REQ-022 IDLE, accepted, ex_wen=0: no write; wb_valid=0 next cycle.
REQ-023 IDLE, accepted, ex_is_load=1: latch ex_rd, clear timeout counter, go LOAD_WAIT; wb_valid=0 next cycle.
REQ-024 LOAD_WAIT with mem_rvalid=1: WB register SHALL load {latched rd, mem_rdata}, wb_valid=1 next cycle, return IDLE.
REQ-025 LOAD_WAIT without mem_rvalid: counter increments; on cycle counter==LOAD_TIMEOUT-1, load_err SHALL pulse 1 cycle, no write, return IDLE.
REQ-026 mem_rvalid coincident with timeout SHALL win: data written, load_err stays 0.
REQ-027 mem_rvalid in IDLE SHALL be ignored.
REQ-028 Register file write SHALL occur at the edge ending each cycle with wb_valid=1 and wb_rd!=0; wb_valid lasts exactly 1 cycle per result.
REQ-029 Register 0 SHALL read 0 always and never be written.
REQ-030 Reads SHALL be combinational from array contents (plus bypass per REQ-034).

Reset
REQ-031 On rst_n=1 at a clock edge: all 16 registers 0, state IDLE, wb_valid 0, wb_rd 0, wb_data 0, load_err 0, counter 0.
REQ-032 Reset during LOAD_WAIT SHALL abort the load; later mem_rvalid causes no write.
REQ-033 Reset coincident with wb_valid=1 SHALL suppress that write.

Configuration
REQ-034 Macro WB_BYPASS_EN defined: rsN_rdata SHALL return wb_data when wb_valid=1, wb_rd==rsN_addr and rsN_addr!=0; undefined: rsN_rdata returns array contents only (new value visible cycle after wb_valid).

Structure
REQ-035 Shared package SHALL hold DATA_W/ADDR_W defaults, the FSM state encoding, and the register-0 constant.
REQ-036 Storage SHALL be sub-module regfile_16x16 (1 write, 2 combinational read ports, sync reset); FSM, WB register, counter, bypass at top.

Verification
REQ-037 ALU write: ex_rd=3, res=0x1234 accepted -> wb_valid=1 next cycle; r3 reads 0x1234 cycle after (same cycle iff WB_BYPASS_EN).
REQ-038 Load: ex_is_load, rd=5; mem_rvalid after 4 cycles with 0xBEEF -> stall/ex_ready held 4+1 cycles, r5=0xBEEF.
REQ-039 Timeout: load rd=6, no mem_rvalid -> load_err pulses on the 15th LOAD_WAIT cycle, r6 unchanged, ex_ready=1 next.
REQ-040 Write rd=0 with 0xFFFF -> r0 reads 0x0000 (both configs).
REQ-041 Reset asserted mid LOAD_WAIT, then mem_rvalid=1 with 0x5555 -> no write, state IDLE, all reads 0.
REQ-042 mem_rvalid on the timeout cycle with 0x00A5 -> written, load_err=0.
